// File: rtl/select_slot_navigator.sv
// Occupied-slot selector for the parking-lot UI: debounced prev/next buttons step the
// selection to the neighbouring occupied slot with wrap-around, and reselect when a car leaves.

module ssn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pulse_o
);
  localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

  logic          s1_q, s2_q, lvl_q, lvl_dly_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      lvl_dly_q <= lvl_q;
      // Level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
      if (s2_q != lvl_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          lvl_q <= ~lvl_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = lvl_q & ~lvl_dly_q;
endmodule

module select_slot_navigator #(
  parameter int NUM_SLOTS    = 24,
  parameter int ADDR_W       = 5,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_SLOTS-1:0] car_storage_i,
  input  logic                 button_prev_i,
  input  logic                 button_next_i,
  output logic [ADDR_W-1:0]    current_addr_o,
  output logic                 addr_valid_o,
  output logic                 busy_o
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic {IDLE, SCAN} state_e;

  logic [1:0]        btn_pulse;
  logic              prv_pulse, nxt_pulse;
  state_e            state_q;
  logic [ADDR_W-1:0] cand_q, addr_q;
  logic              dir_q;  // 1 = stepping downwards
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q, busy_q;

  ssn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn [1:0] (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  ({button_next_i, button_prev_i}),
    .pulse_o(btn_pulse)
  );

  assign prv_pulse = btn_pulse[0];
  assign nxt_pulse = btn_pulse[1];

  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(NUM_SLOTS - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] dec(input logic [ADDR_W-1:0] a);
    return (a == '0) ? ADDR_W'(NUM_SLOTS - 1) : a - 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cand_q  <= '0;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (nxt_pulse | prv_pulse) begin
            // Simultaneous presses are ambiguous and are dropped.
            if (nxt_pulse ^ prv_pulse) begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
              dir_q   <= prv_pulse;
              cand_q  <= prv_pulse ? dec(addr_q) : inc(addr_q);
              cnt_q   <= CNT_W'(1);
            end
          end else if (valid_q && !car_storage_i[addr_q]) begin
            valid_q <= 1'b0;
            state_q <= SCAN;
            busy_q  <= 1'b1;
            dir_q   <= 1'b0;
            cand_q  <= inc(addr_q);
            cnt_q   <= CNT_W'(1);
          end else if (!valid_q && |car_storage_i) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            dir_q   <= 1'b0;
            cand_q  <= addr_q;
            cnt_q   <= CNT_W'(1);
          end
        end
        SCAN: begin
          if (car_storage_i[cand_q]) begin
            addr_q  <= cand_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(NUM_SLOTS)) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cand_q <= dir_q ? dec(cand_q) : inc(cand_q);
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign current_addr_o = addr_q;
  assign addr_valid_o   = valid_q;
  assign busy_o         = busy_q;
endmodule

// File: tb/tb_select_slot_navigator.sv
// Randomised bench for select_slot_navigator: a slot-list model predicts the selected slot,
// the scan distance and the exact update edge for each press and car departure.

module tb_select_slot_navigator;
  localparam int NS = 24;
  localparam int AW = 5;
  localparam int DC = 2;

  logic          clk, rst_n, bprev, bnext;
  logic [NS-1:0] storage;
  logic [AW-1:0] addr;
  logic          valid, busy;

  int            checks = 0;
  int            errors = 0;
  int            m_addr;
  logic          m_valid;
  logic [NS-1:0] mask;

  select_slot_navigator #(.NUM_SLOTS(NS), .ADDR_W(AW), .DEBOUNCE_CYC(DC)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .car_storage_i (storage),
    .button_prev_i (bprev),
    .button_next_i (bnext),
    .current_addr_o(addr),
    .addr_valid_o  (valid),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Distance 1..NS to the first occupied slot stepping from a in direction dir.
  function automatic int step_dist(input int a, input int dir, input logic [NS-1:0] m,
                                   output int idx);
    for (int k = 1; k <= NS; k++) begin
      idx = (((a + dir * k) % NS) + NS) % NS;
      if (m[idx]) return k;
    end
    idx = a;
    return 0;
  endfunction

  // Offset 0..NS-1 to the first occupied slot at or above a, -1 if lot empty.
  function automatic int fwd_incl(input int a, input logic [NS-1:0] m, output int idx);
    for (int k = 0; k < NS; k++) begin
      idx = (a + k) % NS;
      if (m[idx]) return k;
    end
    idx = a;
    return -1;
  endfunction

  task automatic press(input int dir);
    int d, exp_idx, bcnt, last;
    d    = step_dist(m_addr, dir, mask, exp_idx);
    last = DC + 3 + d;
    bcnt = 0;
    if (dir > 0) bnext = 1'b1; else bprev = 1'b1;
    for (int e = 1; e <= last; e++) begin
      tick();
      if (busy) bcnt++;
      if (e == last - 1) chk("press_addr_before", addr, m_addr);
    end
    chk("press_addr", addr, exp_idx);
    chk("press_valid", valid, 1);
    chk("press_busy_cycles", bcnt, d);
    bnext = 1'b0;
    bprev = 1'b0;
    repeat (DC + 4) tick();
    chk("press_settled_busy", busy, 0);
    m_addr = exp_idx;
  endtask

  // Selected car leaves: newm must not contain the selected slot.
  task automatic car_left(input logic [NS-1:0] newm);
    int d, exp_idx;
    mask    = newm;
    storage = newm;
    tick();
    chk("left_valid_fall", valid, 0);
    chk("left_busy", busy, 1);
    if (newm != '0) begin
      d = step_dist(m_addr, 1, newm, exp_idx);
      repeat (d - 1) tick();
      chk("left_addr_before", addr, m_addr);
      tick();
      chk("left_addr", addr, exp_idx);
      chk("left_valid", valid, 1);
      m_addr = exp_idx;
    end else begin
      repeat (NS) tick();
      chk("empty_addr_held", addr, m_addr);
      chk("empty_valid", valid, 0);
      chk("empty_busy", busy, 0);
      m_valid = 1'b0;
    end
  endtask

  // Unselected with cars present: inclusive forward search from the held address.
  task automatic auto_scan(input logic [NS-1:0] newm);
    int k, exp_idx;
    mask    = newm;
    storage = newm;
    k = fwd_incl(m_addr, newm, exp_idx);
    tick();
    chk("auto_busy", busy, 1);
    repeat (k) tick();
    chk("auto_valid_before", valid, 0);
    tick();
    chk("auto_addr", addr, exp_idx);
    chk("auto_valid", valid, 1);
    chk("auto_busy_done", busy, 0);
    m_addr  = exp_idx;
    m_valid = 1'b1;
  endtask

  task automatic quiet_window(input string tag, input int n);
    logic seen;
    int   a0;
    seen = 1'b0;
    a0   = m_addr;
    repeat (n) begin
      tick();
      seen |= busy;
    end
    chk({tag, "_busy"}, seen, 0);
    chk({tag, "_addr"}, addr, a0);
  endtask

  initial begin
    logic [NS-1:0] r;
    rst_n   = 1'b0;
    bprev   = 1'b0;
    bnext   = 1'b0;
    storage = '0;
    mask    = '0;
    m_addr  = 0;
    m_valid = 1'b0;
    repeat (3) tick();
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_empty_busy", busy, 0);

    auto_scan(24'h000210);
    press(1);
    press(1);
    press(-1);
    car_left(24'h000010);
    press(1);

    // Single-cycle glitch, then both buttons together.
    mask    = 24'h000210;
    storage = mask;
    bnext   = 1'b1;
    tick();
    bnext = 1'b0;
    quiet_window("glitch", DC + 10);
    bnext = 1'b1;
    bprev = 1'b1;
    quiet_window("both", DC + 8);
    bnext = 1'b0;
    bprev = 1'b0;
    repeat (DC + 4) tick();

    press(1);
    car_left(24'h000010);
    car_left(24'h000000);

    // Reset during a long scan.
    auto_scan(24'h800000);
    bnext = 1'b1;
    repeat (DC + 3 + 5) tick();
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", addr, 0);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_busy", busy, 0);
    bnext = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    m_addr  = 0;
    m_valid = 1'b0;
    auto_scan(24'h800000);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) != 3) begin
        r       = NS'($urandom()) | (NS'(1) << m_addr);
        mask    = r;
        storage = r;
        tick();
        press(($urandom_range(0, 1) == 1) ? 1 : -1);
      end else begin
        r = ($urandom_range(0, 4) == 0) ? '0 : (NS'($urandom()) & ~(NS'(1) << m_addr));
        car_left(r);
        if (!m_valid) begin
          r = NS'($urandom()) | (NS'(1) << $urandom_range(0, NS - 1));
          auto_scan(r);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
